if_fetch_unit: RTL and testbench

Instruction fetch stage for the 64-bit pipelined core. It produces the `PC_out`/`Instruction` pair that the IF/ID pipeline register captures, and it owns the program counter. A small fetch queue absorbs decode stalls and the fixed one-cycle instruction-memory read latency. Branch and jump redirects from later stages flush in-flight fetches.

---
 rtl/if_fetch_unit.sv | 129 ++++++++++++
 tb/tb_if_fetch_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one-cycle-latency imem reads and
// buffers responses in a small queue. Optional macro: FETCH_MISALIGN_TRAP_EN.
module if_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        id_stall,
  output logic        fetch_valid,
  output logic [63:0] PC_out,
  output logic [31:0] Instruction
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        fetch_misaligned
`endif
);

  localparam int AW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(FQ_DEPTH);

  logic [63:0]   pc_q, pc_d;
  logic          inflight_q, inflight_d;
  logic [63:0]   inflight_pc_q, inflight_pc_d;
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [63:0]   fq_pc_q   [FQ_DEPTH];
  logic [31:0]   fq_inst_q [FQ_DEPTH];

  logic          deq;
  logic          wr_en;
  logic [CW:0]   occupancy;
  logic [63:0]   redirect_target;
  logic          issue_blocked;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
  assign redirect_target  = redirect_pc;
  assign issue_blocked    = misalign_q;
  assign fetch_misaligned = misalign_q;
`else
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign redirect_target      = {redirect_pc[63:2], 2'b00};
  assign issue_blocked        = 1'b0;
`endif

  assign fetch_valid = (count_q != '0);
  assign PC_out      = fetch_valid ? fq_pc_q[head_q]   : 64'h0;
  assign Instruction = fetch_valid ? fq_inst_q[head_q] : 32'h0;
  assign imem_addr   = pc_q;

  assign deq   = fetch_valid && !id_stall;
  assign wr_en = inflight_q && !redirect_valid;

  // Counting the in-flight request as occupied guarantees its response a free slot.
  assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, deq};
  assign imem_req  = !reset && !redirect_valid && !issue_blocked && (occupancy < DEPTH_L);

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = imem_req;
    inflight_pc_d = inflight_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign_d    = misalign_q;
`endif
    if (redirect_valid) begin
      pc_d    = redirect_target;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_d = |redirect_pc[1:0];
`endif
    end else begin
      if (imem_req) begin
        pc_d          = pc_q + 64'd4;
        inflight_pc_d = pc_q;
      end
      if (wr_en) tail_d = tail_q + 1'b1;
      if (deq)   head_d = head_q + 1'b1;
      count_d = count_q + {{(CW-1){1'b0}}, wr_en} - {{(CW-1){1'b0}}, deq};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 64'h0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q    <= 1'b0;
`endif
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q    <= misalign_d;
`endif
    end
  end

  // Queue storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      fq_pc_q[tail_q]   <= inflight_pc_q;
      fq_inst_q[tail_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed fetch scenarios, an imem model with one-cycle
// latency, and a scoreboard monitor checking every instruction accepted by decode.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        id_stall = 1'b0;
  logic        fetch_valid;
  logic [63:0] PC_out;
  logic [31:0] Instruction;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misaligned;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [95:0] exp_q[$];
  logic [95:0] mon_e;
  bit          mon_en = 1'b0;

  if_fetch_unit #(.RESET_PC(64'h0), .FQ_DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_stall       (id_stall),
    .fetch_valid    (fetch_valid),
    .PC_out         (PC_out),
    .Instruction    (Instruction)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_misaligned (fetch_misaligned)
`endif
  );

  // clock / reset block
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h0000_0013;
  endfunction

  // instruction memory: data one cycle after the request
  always @(posedge clk) begin
    imem_rdata <= imem_req ? mem_word(imem_addr) : 32'hBAD0_BAD0;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [63:0] pc);
    exp_q.push_back({pc, mem_word(pc)});
  endtask

  task automatic start_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    id_stall       = 1'b0;
    redirect_pc    = 64'h0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_fetch_valid", fetch_valid, 0);
    chk("rst_pc_out", PC_out, 0);
    chk("rst_instruction", Instruction, 0);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_imem_addr", imem_addr, 64'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("rst_misaligned", fetch_misaligned, 0);
`endif
    mon_en = 1'b1;
    start_cycle();
    reset = 1'b0;
  endtask

  // scoreboard monitor: every instruction decode accepts must match the queue head
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (!fetch_valid) begin
        chk("idle_pc_zero", PC_out, 0);
        chk("idle_inst_zero", {32'h0, Instruction}, 0);
      end else if (!id_stall && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got pc %h, expected no output", PC_out);
        end else begin
          mon_e = exp_q.pop_front();
          chk("stream_pc", PC_out, mon_e[95:32]);
          chk("stream_inst", {32'h0, Instruction}, {32'h0, mon_e[31:0]});
        end
      end
    end
  end

  // driver
  initial begin
    do_reset();

    // scenario 1: straight-line fetch, then a 5-cycle decode stall
    push_exp(64'h0); push_exp(64'h4); push_exp(64'h8); push_exp(64'hC); push_exp(64'h10);
    for (int c = 0; c < 12; c++) begin
      id_stall = (c >= 3 && c <= 7);
      @(negedge clk);
      if (c <= 2) begin
        chk("s1_req", imem_req, 1);
        chk("s1_addr", imem_addr, 64'(4 * c));
      end
      if (c >= 3 && c <= 7) begin
        chk("s1_hold_pc", PC_out, 64'h4);
        chk("s1_hold_valid", fetch_valid, 1);
      end
      if (c >= 4 && c <= 7) chk("s1_full_noreq", imem_req, 0);
      if (c == 8) chk("s1_resume_addr", imem_addr, 64'hC);
      start_cycle();
    end
    id_stall = 1'b0;
    chk("s1_drained", exp_q.size(), 0);
    do_reset();

    // scenario 2: redirect at cycle 6 to 0x100
    push_exp(64'h0); push_exp(64'h4); push_exp(64'h8); push_exp(64'hC);
    push_exp(64'h100); push_exp(64'h104); push_exp(64'h108);
    for (int c = 0; c < 12; c++) begin
      redirect_valid = (c == 6);
      redirect_pc    = 64'h100;
      @(negedge clk);
      if (c == 6) chk("s2_redir_noreq", imem_req, 0);
      if (c == 7 || c == 8) chk("s2_bubble", fetch_valid, 0);
      if (c == 7) begin
        chk("s2_target_req", imem_req, 1);
        chk("s2_target_addr", imem_addr, 64'h100);
      end
      start_cycle();
    end
    redirect_valid = 1'b0;
    chk("s2_drained", exp_q.size(), 0);
    do_reset();

    // scenario 3: redirect while stalled with a full queue
    push_exp(64'h3000); push_exp(64'h3004);
    for (int c = 0; c < 9; c++) begin
      id_stall       = (c >= 2 && c <= 4);
      redirect_valid = (c == 4);
      redirect_pc    = 64'h3000;
      @(negedge clk);
      if (c == 3) begin
        chk("s3_full_noreq", imem_req, 0);
        chk("s3_head_pc", PC_out, 64'h0);
        chk("s3_head_valid", fetch_valid, 1);
      end
      if (c == 4) chk("s3_redir_noreq", imem_req, 0);
      if (c == 5 || c == 6) chk("s3_bubble", fetch_valid, 0);
      if (c == 5) chk("s3_target_addr", imem_addr, 64'h3000);
      start_cycle();
    end
    id_stall = 1'b0;
    redirect_valid = 1'b0;
    chk("s3_drained", exp_q.size(), 0);
    do_reset();

    // scenario 4: PC wraps past the top of the address space
    push_exp(64'h0); push_exp(64'hFFFF_FFFF_FFFF_FFFC); push_exp(64'h0); push_exp(64'h4);
    for (int c = 0; c < 9; c++) begin
      redirect_valid = (c == 3);
      redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
      @(negedge clk);
      if (c == 4) chk("s4_top_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      if (c == 5) chk("s4_wrap_addr", imem_addr, 64'h0);
      if (c == 4 || c == 5) chk("s4_bubble", fetch_valid, 0);
      start_cycle();
    end
    redirect_valid = 1'b0;
    chk("s4_drained", exp_q.size(), 0);
    do_reset();

`ifdef FETCH_MISALIGN_TRAP_EN
    // scenario 5: misaligned redirect traps, aligned redirect recovers
    push_exp(64'h0); push_exp(64'h200); push_exp(64'h204);
    for (int c = 0; c < 12; c++) begin
      redirect_valid = (c == 3 || c == 7);
      redirect_pc    = (c == 7) ? 64'h200 : 64'h102;
      @(negedge clk);
      if (c >= 4 && c <= 6) begin
        chk("s5_trap_flag", fetch_misaligned, 1);
        chk("s5_trap_noreq", imem_req, 0);
        chk("s5_trap_novalid", fetch_valid, 0);
      end
      if (c == 8) begin
        chk("s5_clear_flag", fetch_misaligned, 0);
        chk("s5_clear_req", imem_req, 1);
        chk("s5_clear_addr", imem_addr, 64'h200);
      end
      start_cycle();
    end
`else
    // scenario 5: misaligned redirect target is truncated to a word boundary
    push_exp(64'h0); push_exp(64'h100); push_exp(64'h104);
    for (int c = 0; c < 8; c++) begin
      redirect_valid = (c == 3);
      redirect_pc    = 64'h102;
      @(negedge clk);
      if (c == 4) chk("s5_aligned_addr", imem_addr, 64'h100);
      start_cycle();
    end
`endif
    redirect_valid = 1'b0;
    chk("s5_drained", exp_q.size(), 0);
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
